// File: rtl/conv3x3_window_mac_pkg.sv
// rtl/conv3x3_window_mac_pkg.sv - shared constants and helpers for the 3x3 window MAC
package conv3x3_window_mac_pkg;

  localparam int NUM_TAPS = 9;
  localparam int KROWS    = 3;
  localparam int KCOLS    = 3;

  // Nine products of (BIT_DEPTH+1)x(WGT_W) signed values fit in BIT_DEPTH+WGT_W+5 bits.
  function automatic int acc_width(input int bit_depth, input int wgt_w);
    return bit_depth + wgt_w + 5;
  endfunction

  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/conv3x3_window_mac_mac9_tree.sv
// rtl/conv3x3_window_mac_mac9_tree.sv - registered 9-tap multiply stage plus registered adder tree
module conv3x3_window_mac_mac9_tree
  import conv3x3_window_mac_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int WGT_W     = 8,
  parameter int RELU      = 0,
  parameter int ACC_W     = acc_width(BIT_DEPTH, WGT_W)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic [NUM_TAPS-1:0][BIT_DEPTH-1:0]   pix,
  input  logic [NUM_TAPS-1:0][WGT_W-1:0]       taps,
  output logic signed [ACC_W-1:0]              sum
);

  localparam int PROD_W = BIT_DEPTH + WGT_W + 1;

  logic signed [PROD_W-1:0] prod [NUM_TAPS];
  logic signed [ACC_W-1:0]  tree;

  // Pixels are unsigned, so a zero MSB keeps them positive in the signed multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) prod[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < NUM_TAPS; i++)
        prod[i] <= PROD_W'($signed({1'b0, pix[i]})) * PROD_W'($signed(taps[i]));
    end
  end

  always_comb begin
    tree = '0;
    for (int i = 0; i < NUM_TAPS; i++) tree = tree + ACC_W'(prod[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (en) begin
      sum <= (RELU != 0 && tree[ACC_W-1]) ? '0 : tree;
    end
  end

endmodule

// File: rtl/conv3x3_window_mac.sv
// rtl/conv3x3_window_mac.sv - sliding 3x3 window over linebuffer columns, convolved with a loadable kernel
module conv3x3_window_mac
  import conv3x3_window_mac_pkg::*;
#(
  parameter int  BIT_DEPTH = 8,
  parameter int  WGT_W     = 8,
  parameter int  COLS      = 28,
  parameter int  RELU      = 0,
  localparam int ACC_W     = acc_width(BIT_DEPTH, WGT_W),
  localparam int COL_W     = clog2(COLS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    wgt_load,
  input  logic [3:0]              wgt_idx,
  input  logic [WGT_W-1:0]        wgt_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIT_DEPTH-1:0]    in_r1,
  input  logic [BIT_DEPTH-1:0]    in_r2,
  input  logic [BIT_DEPTH-1:0]    in_r3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [COL_W-1:0]        out_col,
  output logic                    row_done
);

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] FIRST_WIN = COL_W'(2);

  logic                                advance;
  logic                                accept;
  logic [COL_W-1:0]                    col_cnt;
  logic [BIT_DEPTH-1:0]                win [KROWS][KCOLS];
  logic [BIT_DEPTH-1:0]                in_col [KROWS];
  logic                                win_valid, win_last, prod_valid, prod_last;
  logic [COL_W-1:0]                    win_col, prod_col;
  logic [WGT_W-1:0]                    tap_q [NUM_TAPS];
  logic [NUM_TAPS-1:0][WGT_W-1:0]      tap_eff;
  logic [NUM_TAPS-1:0][BIT_DEPTH-1:0]  win_flat;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) tap_q[i] <= '0;
    end else if (wgt_load && wgt_idx < 4'(NUM_TAPS)) begin
      tap_q[wgt_idx] <= wgt_data;
    end
  end

  // A tap written on this edge is forwarded so a product captured on the same edge sees it.
  always_comb begin
    in_col[0] = in_r1;
    in_col[1] = in_r2;
    in_col[2] = in_r3;
    for (int i = 0; i < NUM_TAPS; i++)
      tap_eff[i] = (wgt_load && wgt_idx == 4'(i)) ? wgt_data : tap_q[i];
    for (int r = 0; r < KROWS; r++)
      for (int c = 0; c < KCOLS; c++)
        win_flat[r*KCOLS + c] = win[r][c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt   <= '0;
      win_valid <= 1'b0;
      win_col   <= '0;
      win_last  <= 1'b0;
      for (int r = 0; r < KROWS; r++)
        for (int c = 0; c < KCOLS; c++) win[r][c] <= '0;
    end else if (flush) begin
      col_cnt   <= '0;
      win_valid <= 1'b0;
      for (int r = 0; r < KROWS; r++)
        for (int c = 0; c < KCOLS; c++) win[r][c] <= '0;
    end else if (advance) begin
      win_valid <= accept && (col_cnt >= FIRST_WIN);
      if (accept) begin
        for (int r = 0; r < KROWS; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
          win[r][2] <= in_col[r];
        end
        win_col  <= col_cnt - FIRST_WIN;
        win_last <= (col_cnt == LAST_COL);
        col_cnt  <= (col_cnt == LAST_COL) ? '0 : col_cnt + 1'b1;
      end
    end
  end

  // Sideband travels alongside the two arithmetic stages inside the tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_valid <= 1'b0;
      prod_col   <= '0;
      prod_last  <= 1'b0;
      out_valid  <= 1'b0;
      out_col    <= '0;
      row_done   <= 1'b0;
    end else if (flush) begin
      prod_valid <= 1'b0;
      out_valid  <= 1'b0;
    end else if (advance) begin
      prod_valid <= win_valid;
      prod_col   <= win_col;
      prod_last  <= win_last;
      out_valid  <= prod_valid;
      out_col    <= prod_col;
      row_done   <= prod_last;
    end
  end

  conv3x3_window_mac_mac9_tree #(
    .BIT_DEPTH (BIT_DEPTH),
    .WGT_W     (WGT_W),
    .RELU      (RELU),
    .ACC_W     (ACC_W)
  ) u_mac9_tree (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (advance),
    .pix   (win_flat),
    .taps  (tap_eff),
    .sum   (out_data)
  );

endmodule
